// File: rtl/mac_col_acc_if.sv
// Bus bundle for one attention-array MAC column: instruction/query inputs,
// systolic pass-through outputs and the FIFO result port.
interface mac_col_acc_if #(
  parameter int unsigned BW       = 8,
  parameter int unsigned PR       = 8,
  parameter int unsigned BW_PSUM  = 2*BW+6,
  parameter int unsigned COL_ID_W = 4,
  parameter int unsigned CNT_W    = 8
);
  logic [2:0]          i_inst;
  logic [PR*BW-1:0]    q_in;
  logic [COL_ID_W-1:0] col_id;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          o_inst;
  logic [PR*BW-1:0]    q_out;
  logic [BW_PSUM-1:0]  out;
  logic                fifo_wr;

  modport master (
    output i_inst, q_in, col_id, cnt_q,
    input  o_inst, q_out, out, fifo_wr
  );

  modport slave (
    input  i_inst, q_in, col_id, cnt_q,
    output o_inst, q_out, out, fifo_wr
  );
endinterface

// File: rtl/mac_col_acc.sv
// MAC column with double-buffered key, pipelined signed dot product and
// multi-beat accumulation ahead of the output FIFO write strobe.
module mac_col_acc #(
  parameter int unsigned BW         = 8,
  parameter int unsigned PR         = 8,
  parameter int unsigned BW_PSUM    = 2*BW+6,
  parameter int unsigned MAC_LAT    = 2,
  parameter int unsigned COL_ID_W   = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned KEY_STRIDE = 2,
  parameter int unsigned KEY_OFFSET = 1
) (
  input logic           clk,
  input logic           reset,
  mac_col_acc_if.slave  bus
);
  localparam int unsigned VW   = PR*BW;
  localparam int unsigned PW   = 2*BW;
  localparam int unsigned LAST = MAC_LAT-1;

  logic [2:0]          inst_q, inst_d;
  logic [VW-1:0]       q_q, q_d;
  logic [VW-1:0]       key_act_q, key_act_d;
  logic [VW-1:0]       key_shadow_q, key_shadow_d;
  logic                shadow_full_q, shadow_full_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    key_tgt_c;
  logic                capture_c, promote_c;

  logic signed [PW-1:0]      prod_c;
  logic signed [BW_PSUM-1:0] dot_c;
  logic [BW_PSUM-1:0]        pdot_q [MAC_LAT];
  logic [MAC_LAT-1:0]        pvld_q, pcont_q;

  logic [BW_PSUM-1:0] acc_q, acc_d, out_q, out_d, acc_next_c;
  logic               acc_open_q, acc_open_d, fifo_wr_q, fifo_wr_d;

  // Capture target wraps at CNT_W bits
  assign key_tgt_c = CNT_W'(32'(bus.col_id) * KEY_STRIDE + KEY_OFFSET);
  assign capture_c = bus.i_inst[0] & armed_q & (bus.cnt_q == key_tgt_c);
  assign promote_c = bus.i_inst[1] & shadow_full_q;

  // Pass-through and key double-buffer next state
  always_comb begin
    inst_d        = bus.i_inst;
    q_d           = q_q;
    key_act_d     = key_act_q;
    key_shadow_d  = key_shadow_q;
    shadow_full_d = shadow_full_q;
    armed_d       = armed_q;
    if (bus.i_inst[1] | bus.i_inst[0]) q_d = bus.q_in;
    // Promotion reads the pre-edge shadow; a same-cycle capture refills it
    if (promote_c) begin
      key_act_d     = key_shadow_q;
      shadow_full_d = 1'b0;
    end
    if (capture_c) begin
      key_shadow_d  = bus.q_in;
      shadow_full_d = 1'b1;
    end
    if (!bus.i_inst[0])  armed_d = 1'b1;
    else if (capture_c)  armed_d = 1'b0;
  end

  // Signed dot product of the registered query against the active key
  always_comb begin
    prod_c = '0;
    dot_c  = '0;
    for (int k = 0; k < int'(PR); k++) begin
      prod_c = PW'($signed(q_q[k*BW +: BW])) * PW'($signed(key_act_q[k*BW +: BW]));
      dot_c  = dot_c + BW_PSUM'(prod_c);
    end
  end

  // Accumulate stage next state
  always_comb begin
    acc_next_c = (acc_open_q ? acc_q : '0) + pdot_q[LAST];
    acc_d      = acc_q;
    out_d      = out_q;
    acc_open_d = acc_open_q;
    fifo_wr_d  = 1'b0;
    if (pvld_q[LAST]) begin
      acc_d      = acc_next_c;
      out_d      = acc_next_c;
      acc_open_d = pcont_q[LAST];
      fifo_wr_d  = ~pcont_q[LAST];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q        <= '0;
      q_q           <= '0;
      key_act_q     <= '0;
      key_shadow_q  <= '0;
      shadow_full_q <= 1'b0;
      armed_q       <= 1'b1;
      acc_q         <= '0;
      out_q         <= '0;
      acc_open_q    <= 1'b0;
      fifo_wr_q     <= 1'b0;
    end else begin
      inst_q        <= inst_d;
      q_q           <= q_d;
      key_act_q     <= key_act_d;
      key_shadow_q  <= key_shadow_d;
      shadow_full_q <= shadow_full_d;
      armed_q       <= armed_d;
      acc_q         <= acc_d;
      out_q         <= out_d;
      acc_open_q    <= acc_open_d;
      fifo_wr_q     <= fifo_wr_d;
    end
  end

  // MAC pipeline; execute-valid and continue flag travel with the data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MAC_LAT); i++) pdot_q[i] <= '0;
      pvld_q  <= '0;
      pcont_q <= '0;
    end else begin
      pdot_q[0]  <= dot_c;
      pvld_q[0]  <= inst_q[1];
      pcont_q[0] <= inst_q[2];
      for (int i = 1; i < int'(MAC_LAT); i++) begin
        pdot_q[i]  <= pdot_q[i-1];
        pvld_q[i]  <= pvld_q[i-1];
        pcont_q[i] <= pcont_q[i-1];
      end
    end
  end

  assign bus.o_inst  = inst_q;
  assign bus.q_out   = q_q;
  assign bus.out     = out_q;
  assign bus.fifo_wr = fifo_wr_q;
endmodule

// File: tb/tb_mac_col_acc.sv
// Directed bench for mac_col_acc: key capture/promotion, latency,
// accumulation chains, signed wrap, load+execute overlap and async reset.
module tb_mac_col_acc;
  localparam int unsigned BW       = 8;
  localparam int unsigned PR       = 8;
  localparam int unsigned BW_PSUM  = 2*BW+6;
  localparam int unsigned MAC_LAT  = 2;
  localparam int unsigned COL_ID_W = 4;
  localparam int unsigned CNT_W    = 8;

  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;
  int   wr_cnt;
  logic [BW_PSUM-1:0] last_out;

  always #5 clk = ~clk;

  mac_col_acc_if #(.BW(BW), .PR(PR), .BW_PSUM(BW_PSUM), .COL_ID_W(COL_ID_W), .CNT_W(CNT_W)) bus ();

  mac_col_acc #(
    .BW(BW), .PR(PR), .BW_PSUM(BW_PSUM), .MAC_LAT(MAC_LAT),
    .COL_ID_W(COL_ID_W), .CNT_W(CNT_W), .KEY_STRIDE(2), .KEY_OFFSET(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [PR*BW-1:0] vec(input int v);
    logic [PR*BW-1:0] r;
    for (int k = 0; k < int'(PR); k++) r[k*BW +: BW] = BW'(v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int exp);
    logic [BW_PSUM-1:0] e;
    e = BW_PSUM'(exp);
    chk(tag, 64'(last_out), 64'(e));
  endtask

  task automatic clr();
    wr_cnt   = 0;
    last_out = '1;
  endtask

  // Sample outputs at the falling edge, then drive the next beat
  task automatic beat(input logic [2:0] inst, input logic [PR*BW-1:0] q, input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    if (bus.fifo_wr === 1'b1) begin
      wr_cnt++;
      last_out = bus.out;
    end
    bus.i_inst = inst;
    bus.q_in   = q;
    bus.cnt_q  = cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(3'b000, '0, 8'hFF);
  endtask

  task automatic exec1(input string tag, input logic [PR*BW-1:0] q, input int exp);
    clr();
    beat(3'b010, q, 8'hFF);
    idle(4);
    chk({tag, "_wr"}, 64'(wr_cnt), 64'd1);
    chk_out(tag, exp);
  endtask

  initial begin
    reset      = 1'b1;
    bus.i_inst = '0;
    bus.q_in   = '0;
    bus.col_id = 4'd3;
    bus.cnt_q  = '0;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_out",     64'(bus.out),     64'd0);
    chk("rst_fifo_wr", 64'(bus.fifo_wr), 64'd0);
    chk("rst_o_inst",  64'(bus.o_inst),  64'd0);
    chk("rst_q_out",   64'(bus.q_out),   64'd0);
    reset = 1'b0;

    // Pass-through: load beat registers q, idle holds it
    beat(3'b001, vec(5), 8'd0);
    @(posedge clk); #1;
    chk("pt_o_inst", 64'(bus.o_inst), 64'd1);
    chk("pt_q_out",  64'(bus.q_out),  64'(vec(5)));
    beat(3'b000, vec(9), 8'hFF);
    @(posedge clk); #1;
    chk("pt_hold_q",    64'(bus.q_out),  64'(vec(5)));
    chk("pt_o_inst_0",  64'(bus.o_inst), 64'd0);

    // Key load for col_id=3 matches cnt_q=7 only
    for (int c = 0; c < 10; c++) beat(3'b001, vec(c), CNT_W'(c));
    idle(1);
    clr();
    beat(3'b010, vec(1), 8'hFF);
    idle(3);
    chk("lat_early", 64'(wr_cnt), 64'd0);
    idle(1);
    chk("lat_wr", 64'(wr_cnt), 64'd1);
    chk_out("key7_dot", 56);

    // Armed gate: repeated match inside one burst captures only the first
    beat(3'b001, vec(9), 8'd7);
    beat(3'b001, vec(4), 8'd7);
    idle(1);
    exec1("one_capture", vec(1), 72);

    // Double buffer
    beat(3'b001, vec(2), 8'd7);
    idle(1);
    exec1("db_key2", vec(1), 16);
    clr();
    beat(3'b010, vec(1), 8'hFF);
    beat(3'b001, vec(3), 8'd7);
    idle(4);
    chk("db_old_wr", 64'(wr_cnt), 64'd1);
    chk_out("db_old", 16);
    exec1("db_new", vec(1), 24);

    // Accumulation chain 1,1,1,0 with key 2
    beat(3'b001, vec(2), 8'd7);
    idle(1);
    exec1("acc_pre", vec(1), 16);
    clr();
    beat(3'b110, vec(1), 8'hFF);
    beat(3'b110, vec(1), 8'hFF);
    beat(3'b110, vec(1), 8'hFF);
    beat(3'b010, vec(1), 8'hFF);
    idle(6);
    chk("chain_wr", 64'(wr_cnt), 64'd1);
    chk_out("chain_sum", 64);
    exec1("after_chain", vec(1), 16);

    // Back-to-back standalone beats
    clr();
    beat(3'b010, vec(1), 8'hFF);
    beat(3'b010, vec(2), 8'hFF);
    beat(3'b010, vec(3), 8'hFF);
    idle(5);
    chk("b2b_wr", 64'(wr_cnt), 64'd3);
    chk_out("b2b_last", 48);

    // Signed extremes and accumulator wrap
    beat(3'b001, vec(-128), 8'd7);
    idle(1);
    exec1("neg_sq", vec(-128), 131072);
    clr();
    for (int i = 0; i < 15; i++) beat(3'b110, vec(-128), 8'hFF);
    beat(3'b010, vec(-128), 8'hFF);
    idle(6);
    chk("wrap16_wr", 64'(wr_cnt), 64'd1);
    chk_out("wrap16", -2097152);
    clr();
    for (int i = 0; i < 31; i++) beat(3'b110, vec(-128), 8'hFF);
    beat(3'b010, vec(-128), 8'hFF);
    idle(6);
    chk("wrap32_wr", 64'(wr_cnt), 64'd1);
    chk_out("wrap32", 0);

    // Load+execute: promote old shadow (3), capture new (5)
    beat(3'b001, vec(3), 8'd7);
    idle(1);
    clr();
    beat(3'b011, vec(5), 8'd7);
    idle(4);
    chk("ovl_wr", 64'(wr_cnt), 64'd1);
    chk_out("ovl_key3", 120);
    exec1("ovl_key5", vec(1), 40);

    // Async reset one cycle before the chain's write
    clr();
    beat(3'b110, vec(1), 8'hFF);
    beat(3'b010, vec(1), 8'hFF);
    idle(3);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_out",   64'(bus.out),     64'd0);
    chk("mid_rst_wr",    64'(bus.fifo_wr), 64'd0);
    chk("mid_rst_q_out", 64'(bus.q_out),   64'd0);
    idle(3);
    reset = 1'b0;
    idle(4);
    chk("mid_rst_no_wr", 64'(wr_cnt), 64'd0);
    exec1("post_rst_key", vec(1), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
